// File: rtl/io_input_debounce_if.sv
// Switch/button input bus for io_input_debounce: raw inputs, clear pulse
// and the three 32-bit input ports read by the processor.
interface io_input_debounce_if #(
  parameter int SW_W = 10
);
  logic [SW_W-1:0] sw;
  logic [3:0]      key_n;
  logic            evt_clr;
  logic [31:0]     in_port0;
  logic [31:0]     in_port1;
  logic [31:0]     in_port2;

  modport master (
    output sw,
    output key_n,
    output evt_clr,
    input  in_port0,
    input  in_port1,
    input  in_port2
  );

  modport slave (
    input  sw,
    input  key_n,
    input  evt_clr,
    output in_port0,
    output in_port1,
    output in_port2
  );
endinterface

// File: rtl/io_input_debounce.sv
// Synchronizes and debounces slide switches and push-buttons, and counts key presses.
// Define IO_INPUT_DEBOUNCE_EN to build the per-bit debounce counters.
module io_input_debounce #(
  parameter int SW_W      = 10,
  parameter int DB_CYCLES = 50000,
  parameter int CNT_W     = 16
) (
  input logic              io_clk,
  input logic              resetn,
  io_input_debounce_if.slave bus
);

  localparam int N = SW_W + 4;

  if ((SW_W < 1) || (SW_W > 32) || (DB_CYCLES < 2) || (CNT_W < 1) ||
      ((64'(DB_CYCLES) - 64'd1) >= (64'd1 << CNT_W))) begin : g_cfg_err
    $error("io_input_debounce: illegal SW_W/DB_CYCLES/CNT_W");
  end

  // Keys are inverted on entry so that 1 means pressed everywhere inside.
  logic [N-1:0] raw_s;
  logic [N-1:0] s1_q;
  logic [N-1:0] s2_q;
  logic [N-1:0] stable_q;
  logic [N-1:0] stable_d;
  logic [3:0]   press_s;
  logic [7:0]   cnt_q [4];
  logic [7:0]   cnt_d [4];

  assign raw_s = {~bus.key_n, bus.sw};

`ifdef IO_INPUT_DEBOUNCE_EN
  localparam logic [CNT_W-1:0] DbMax = CNT_W'(DB_CYCLES - 32'sd1);

  logic [CNT_W-1:0] db_q [N];
  logic [CNT_W-1:0] db_d [N];

  // Per-bit debounce: accept s2 once it has differed for DB_CYCLES edges.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      stable_d[i] = stable_q[i];
      db_d[i]     = {CNT_W{1'b0}};
      if (s2_q[i] == stable_q[i]) begin
        db_d[i] = {CNT_W{1'b0}};
      end else if (db_q[i] == DbMax) begin
        stable_d[i] = s2_q[i];
        db_d[i]     = {CNT_W{1'b0}};
      end else begin
        db_d[i] = db_q[i] + CNT_W'(1'b1);
      end
    end
  end

  // Debounce counter registers.
  always_ff @(posedge io_clk) begin
    if (!resetn) begin
      for (int i = 0; i < N; i++) db_q[i] <= {CNT_W{1'b0}};
    end else begin
      for (int i = 0; i < N; i++) db_q[i] <= db_d[i];
    end
  end
`else
  // Without debouncing the stable register mirrors s2 (loaded from s1 on the same edge).
  assign stable_d = s1_q;
`endif

  assign press_s = stable_d[N-1:SW_W] & ~stable_q[N-1:SW_W];

  // Press counters: a clear still lets a coincident press count as one.
  always_comb begin
    for (int k = 0; k < 4; k++) begin
      if (bus.evt_clr) begin
        cnt_d[k] = {7'b0000000, press_s[k]};
      end else begin
        cnt_d[k] = cnt_q[k] + {7'b0000000, press_s[k]};
      end
    end
  end

  // Synchronizer, stable levels and press counters.
  always_ff @(posedge io_clk) begin
    if (!resetn) begin
      s1_q     <= {N{1'b0}};
      s2_q     <= {N{1'b0}};
      stable_q <= {N{1'b0}};
      for (int k = 0; k < 4; k++) cnt_q[k] <= 8'h00;
    end else begin
      s1_q     <= raw_s;
      s2_q     <= s1_q;
      stable_q <= stable_d;
      for (int k = 0; k < 4; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  assign bus.in_port0 = 32'(stable_q[SW_W-1:0]);
  assign bus.in_port1 = {28'h0000000, stable_q[N-1:SW_W]};
  assign bus.in_port2 = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};

endmodule

// File: tb/tb_io_input_debounce.sv
// Directed bench for io_input_debounce (DB_CYCLES=4, SW_W=10); expectations
// follow IO_INPUT_DEBOUNCE_EN when it is defined for the build.
module tb_io_input_debounce;

  localparam int SW_W  = 10;
  localparam int DB    = 4;
  localparam int CNT_W = 16;
  localparam int HOLD  = 10;
`ifdef IO_INPUT_DEBOUNCE_EN
  localparam int LAT_EDGE = 1 + DB;
`else
  localparam int LAT_EDGE = 1;
`endif

  logic io_clk = 1'b0;
  logic resetn = 1'b0;
  int   tests  = 0;
  int   fails  = 0;

  io_input_debounce_if #(.SW_W(SW_W)) bus ();

  io_input_debounce #(
    .SW_W     (SW_W),
    .DB_CYCLES(DB),
    .CNT_W    (CNT_W)
  ) dut (
    .io_clk(io_clk),
    .resetn(resetn),
    .bus   (bus)
  );

  always #5 io_clk = ~io_clk;

  typedef struct {
    logic [9:0]  sw;
    logic [3:0]  key_n;
    logic        clr;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge io_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [31:0] e0,
                         input logic [31:0] e1, input logic [31:0] e2);
    chk({name, ".p0"}, bus.in_port0, e0);
    chk({name, ".p1"}, bus.in_port1, e1);
    chk({name, ".p2"}, bus.in_port2, e2);
  endtask

  task automatic do_reset();
    bus.sw      = 10'h000;
    bus.key_n   = 4'hF;
    bus.evt_clr = 1'b0;
    resetn      = 1'b0;
    tick();
    tick();
    chk_all("reset", 32'h0, 32'h0, 32'h0);
    resetn = 1'b1;
  endtask

  task automatic press(input int k);
    bus.key_n[k] = 1'b0;
    repeat (HOLD) tick();
    bus.key_n[k] = 1'b1;
    repeat (HOLD) tick();
  endtask

  initial begin
    logic [31:0] exp_v;
    bus.sw      = 10'h000;
    bus.key_n   = 4'hF;
    bus.evt_clr = 1'b0;

    vecs[0] = '{10'h2A5, 4'hF, 1'b0, 32'h000002A5, 32'h0, 32'h00000000};
    vecs[1] = '{10'h3FF, 4'hE, 1'b0, 32'h000003FF, 32'h1, 32'h00000001};
    vecs[2] = '{10'h000, 4'hF, 1'b0, 32'h00000000, 32'h0, 32'h00000001};
    vecs[3] = '{10'h000, 4'hA, 1'b0, 32'h00000000, 32'h5, 32'h00010002};
    vecs[4] = '{10'h000, 4'hF, 1'b0, 32'h00000000, 32'h0, 32'h00010002};
    vecs[5] = '{10'h000, 4'h0, 1'b0, 32'h00000000, 32'hF, 32'h01020103};
    vecs[6] = '{10'h155, 4'hF, 1'b0, 32'h00000155, 32'h0, 32'h01020103};
    vecs[7] = '{10'h155, 4'hF, 1'b1, 32'h00000155, 32'h0, 32'h00000000};

    // Steady-state table
    do_reset();
    for (int v = 0; v < 8; v++) begin
      bus.sw      = vecs[v].sw;
      bus.key_n   = vecs[v].key_n;
      bus.evt_clr = vecs[v].clr;
      tick();
      bus.evt_clr = 1'b0;
      repeat (HOLD + 2) tick();
      chk_all($sformatf("vec%0d", v), vecs[v].e0, vecs[v].e1, vecs[v].e2);
    end

    // Switch latency, edge by edge
    do_reset();
    tick();
    bus.sw = 10'h2A5;
    for (int e = 0; e <= LAT_EDGE + 1; e++) begin
      tick();
      chk($sformatf("lat_sw_e%0d", e), bus.in_port0,
          (e >= LAT_EDGE) ? 32'h000002A5 : 32'h00000000);
    end

    // Short key glitch
    do_reset();
    tick();
    bus.key_n[1] = 1'b0;
    tick();
    tick();
    bus.key_n[1] = 1'b1;
    for (int e = 0; e < HOLD; e++) begin
      tick();
`ifdef IO_INPUT_DEBOUNCE_EN
      chk($sformatf("glitch_key_p1_e%0d", e), bus.in_port1, 32'h0);
      chk($sformatf("glitch_key_p2_e%0d", e), bus.in_port2, 32'h0);
`endif
    end
`ifdef IO_INPUT_DEBOUNCE_EN
    exp_v = 32'h00000000;
`else
    exp_v = 32'h00000100;
`endif
    chk("glitch_key_final_p2", bus.in_port2, exp_v);

    // Two sub-threshold pulses with a one-cycle gap must not accumulate
    do_reset();
    tick();
    bus.sw[0] = 1'b1;
    repeat (3) tick();
    bus.sw[0] = 1'b0;
    tick();
    bus.sw[0] = 1'b1;
    repeat (3) tick();
    bus.sw[0] = 1'b0;
    for (int e = 0; e < HOLD; e++) begin
      tick();
`ifdef IO_INPUT_DEBOUNCE_EN
      chk($sformatf("glitch_sw_e%0d", e), bus.in_port0, 32'h0);
`endif
    end
    chk("glitch_sw_final", bus.in_port0, 32'h0);

    // Pulse of exactly DB cycles is the shortest accepted one
    bus.sw[1] = 1'b1;
    repeat (4) tick();
    bus.sw[1] = 1'b0;
    tick();
`ifdef IO_INPUT_DEBOUNCE_EN
    exp_v = 32'h00000000;
`else
    exp_v = 32'h00000002;
`endif
    chk("min_pulse_e4", bus.in_port0, exp_v);
    tick();
`ifdef IO_INPUT_DEBOUNCE_EN
    exp_v = 32'h00000002;
`else
    exp_v = 32'h00000000;
`endif
    chk("min_pulse_e5", bus.in_port0, exp_v);
    repeat (HOLD) tick();
    chk("min_pulse_settle", bus.in_port0, 32'h0);

    // Three presses on key 2, then clear
    do_reset();
    for (int p = 0; p < 3; p++) press(2);
    chk("key2_x3", bus.in_port2, 32'h00030000);
    bus.evt_clr = 1'b1;
    tick();
    bus.evt_clr = 1'b0;
    chk("key2_clr", bus.in_port2, 32'h00000000);

    // Clear coincident with key 0 acceptance
    do_reset();
    for (int p = 0; p < 5; p++) press(1);
    chk("cnt1_5", bus.in_port2, 32'h00000500);
    bus.key_n[0] = 1'b0;
    repeat (LAT_EDGE) tick();
    chk("key0_pre_accept", bus.in_port1, 32'h0);
    bus.evt_clr = 1'b1;
    tick();
    bus.evt_clr = 1'b0;
    chk("clr_press_p2", bus.in_port2, 32'h00000001);
    chk("clr_press_p1", bus.in_port1, 32'h00000001);
    bus.key_n[0] = 1'b1;
    repeat (HOLD) tick();

    // Counter wrap on key 3
    do_reset();
    for (int p = 0; p < 255; p++) press(3);
    chk("cnt3_255", bus.in_port2, 32'hFF000000);
    press(3);
    chk("cnt3_wrap", bus.in_port2, 32'h00000000);

    // Reset mid-debounce, with clear asserted during reset
    bus.sw[0]    = 1'b1;
    bus.key_n[3] = 1'b0;
    repeat (3) tick();
    resetn      = 1'b0;
    bus.evt_clr = 1'b1;
    tick();
    chk_all("rst_mid", 32'h0, 32'h0, 32'h0);
    tick();
    chk_all("rst_mid_hold", 32'h0, 32'h0, 32'h0);
    bus.evt_clr = 1'b0;
    resetn      = 1'b1;
    for (int e = 0; e <= LAT_EDGE; e++) begin
      tick();
      if (e < LAT_EDGE) begin
        chk_all($sformatf("requal_e%0d", e), 32'h0, 32'h0, 32'h0);
      end else begin
        chk_all($sformatf("requal_e%0d", e), 32'h00000001, 32'h00000008, 32'h01000000);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/io_input_debounce.md
IO_INPUT_DEBOUNCE -- requirements
Module: io_input_debounce

Interface
REQ-001 SHALL have parameter SW_W, default 10: slide-switch count, legal 1..32.
REQ-002 SHALL have parameter DB_CYCLES, default 50000: io_clk cycles a synchronized input must stay changed before acceptance, legal >= 2.
REQ-003 SHALL have parameter CNT_W, default 16: debounce counter width; 2^CNT_W > DB_CYCLES-1 required.
REQ-004 SHALL have port io_clk  input  1  sole clock, all state updates on its rising edge.
REQ-005 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port sw  input  SW_W  raw asynchronous switch levels, 1 = on.
REQ-007 SHALL have port key_n  input  4  raw asynchronous push-buttons, active-low (0 = pressed).
REQ-008 SHALL have port evt_clr  input  1  synchronous one-cycle pulse clearing all press counters.
REQ-009 SHALL have port in_port0  output  32  debounced switches, zero-extended.
REQ-010 SHALL have port in_port1  output  32  {28'b0, debounced key levels}, 1 = pressed.
REQ-011 SHALL have port in_port2  output  32  four 8-bit press counters {cnt3,cnt2,cnt1,cnt0}.

Function
REQ-012 Each input bit SHALL pass a 2-flop synchronizer (s1, s2); key bits inverted before s1 so pressed = 1 internally.
REQ-013 Each bit SHALL own a debounce counter and a stable register; all outputs driven directly from registers.
REQ-014 Per edge, per bit: s2 == stable -> counter <= 0; s2 != stable and counter < DB_CYCLES-1 -> counter + 1; s2 != stable and counter == DB_CYCLES-1 -> stable <= s2, counter <= 0.
REQ-015 Input glitch returning to the stable value before acceptance SHALL reset the counter; no output change.
REQ-016 Latency: raw change captured in s1 at edge k SHALL appear on in_port0/in_port1 at edge k+1+DB_CYCLES.
REQ-017 Key stable 0->1 transition SHALL increment that key's counter on the same edge; 1->0 (release) SHALL not.
REQ-018 Press counters SHALL wrap 255 -> 0.
REQ-019 evt_clr alone SHALL zero all four counters on that edge.
REQ-020 evt_clr coincident with a press on key i SHALL leave cnt_i = 1, all other counters 0.
REQ-021 Simultaneous presses on several keys SHALL each be counted on the same edge.
REQ-022 Bits SHALL be debounced independently; no shared counter.

Reset
REQ-023 resetn low at an io_clk edge SHALL clear s1, s2, stable, debounce counters, press counters; in_port0/1/2 = 32'h0 on that edge.
REQ-024 Reset mid-debounce SHALL discard partial counts; after release held inputs re-qualify per REQ-016 (keys held at release count one press when accepted).
REQ-025 Reset SHALL take priority over evt_clr and all updates.

Configuration
REQ-026 Macro IO_INPUT_DEBOUNCE_EN defined: debounce per REQ-014 to REQ-016.
REQ-027 Macro IO_INPUT_DEBOUNCE_EN undefined: debounce counters not built; stable <= s2 every edge; latency edge k+1; CNT_W, DB_CYCLES ignored; counting/clear rules unchanged.

Verification (DB_CYCLES=4, SW_W=10, macro defined unless noted)
REQ-028 sw 10'h000->10'h2A5 captured at edge 0 -> in_port0 = 32'h000002A5 at edge 5, 32'h0 through edge 4.
REQ-029 key_n[1] low 2 cycles then high -> in_port1 and in_port2 stay 0.
REQ-030 key_n[2] pressed/released (each held 10 cycles) 3 times -> in_port2 = 32'h00030000; evt_clr pulse -> 32'h0 next edge.
REQ-031 key_n[0] acceptance edge coincident with evt_clr, cnt1=5 prior -> in_port2 = 32'h00000001.
REQ-032 256 debounced presses on key 3 -> cnt3 = 0; resetn low mid-debounce of sw[0] -> all outputs 0, sw[0] accepted 5 edges after release.
REQ-033 Macro undefined: sw change captured at edge 0 -> in_port0 updated at edge 1.
